// File: rtl/sm_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, LSU state
// encoding and small helpers that classify a CPU access.
//
// Contents:
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD  access size codes (any other code = word)
//   lsu_state_t                        LSU sequencer states
//   norm_size()                        folds unknown size codes onto SIZE_WORD
//   is_misaligned()                    halfword on odd address, word not on 4-byte boundary
//   last_idx()                         index of the final byte of a split access
package sm_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_SEQ  = 1'b1
  } lsu_state_t;

  // The reserved size code behaves exactly like a word access everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SIZE_BYTE || size == SIZE_HALF) ? size : SIZE_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] size_n;
    size_n = norm_size(size);
    return ((size_n == SIZE_HALF) && addr_lo[0]) ||
           ((size_n == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

  // A split halfword ends on byte 1, a split word on byte 3.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    return (norm_size(size) == SIZE_HALF) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/sm_lsu_ext.sv
// Combinational load extender.
// Takes a low-justified load value and widens it to 32 bits according to the
// access size: bytes extend from bit 7, halfwords from bit 15, words pass through.
//
// Ports:
//   size  in   2   access size code (unknown codes treated as word)
//   uns   in   1   1 = zero-extend, 0 = sign-extend
//   din   in   32  low-justified raw load data
//   dout  out  32  extended result
module sm_lsu_ext
  import sm_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Pick the fill bit once, then replicate it above the live bits of the access.
  always_comb begin
    dout = din;
    case (norm_size(size))
      SIZE_BYTE: dout = {{24{~uns & din[7]}}, din[7:0]};
      SIZE_HALF: dout = {{16{~uns & din[15]}}, din[15:0]};
      default:   dout = din;
    endcase
  end

endmodule

// File: rtl/sm_lsu.sv
// Load/store unit between the CPU execute stage and the data memory.
// Aligned accesses go straight through to memory in the same cycle with the
// load result extended on the way back. Misaligned halfword/word accesses are
// broken into little-endian byte accesses over consecutive cycles while the
// CPU is stalled; with MISALIGN_EN=0 they are rejected with misalign_err.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   req           CPU access request (held by the CPU while stall=1)
//   we            1 = store, 0 = load
//   size          byte / halfword / word (other codes = word)
//   uns           load zero-extension select
//   addr, wdata   byte address and right-justified store data
//   rdata         extended load result, valid with done on loads, else 0
//   done          access completes this cycle
//   stall         CPU must hold the current instruction
//   misalign_err  misaligned access rejected (MISALIGN_EN=0)
//   dm_we, dm_da, dm_a, dm_wd   data memory write enable / size / address / data
//   dm_rd         data memory combinational read data, low-justified
module sm_lsu
  import sm_lsu_pkg::*;
#(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        misalign_err,
  output logic        dm_we,
  output logic [1:0]  dm_da,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  lsu_state_t  state;
  lsu_state_t  state_next;
  logic [1:0]  idx;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [23:0] buffer;

  logic [1:0]  size_n;
  logic        misaligned;
  logic        start_seq;
  logic        seq_last;
  logic [31:0] seq_word;
  logic [7:0]  seq_wbyte;

  logic [1:0]  ext_size;
  logic        ext_uns;
  logic [31:0] ext_in;
  logic [31:0] ext_out;

  logic [31:0] rdata_c;
  logic        done_c;
  logic        stall_c;
  logic        misalign_err_c;
  logic        dm_we_c;

  assign size_n     = norm_size(size);
  assign misaligned = is_misaligned(size, addr[1:0]);
  assign start_seq  = req && misaligned && MISALIGN_EN;
  assign seq_last   = (idx == last_idx(size_q));
  assign seq_wbyte  = 8'(wdata_q >> {idx, 3'b000});

  // State register: reset drops straight back to IDLE, abandoning any split
  // access; bytes already written to memory are deliberately left in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: only a misaligned request leaves IDLE, and the byte
  // sequence always runs to its last byte regardless of req.
  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: if (start_seq) state_next = LSU_SEQ;
      LSU_SEQ:  if (seq_last)  state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  // Split-access context: the request is latched when the sequence starts so
  // the CPU inputs are free to be ignored afterwards. Load bytes collect in
  // the 24-bit buffer; the final byte is never stored, it is merged live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SIZE_BYTE;
      buffer  <= 24'h0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (start_seq) begin
            idx     <= 2'd1;
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            uns_q   <= uns;
            size_q  <= size_n;
            buffer  <= we ? 24'h0 : {16'h0, dm_rd[7:0]};
          end
        end
        LSU_SEQ: begin
          if (!we_q) begin
            case (idx)
              2'd1:    buffer[15:8]  <= dm_rd[7:0];
              2'd2:    buffer[23:16] <= dm_rd[7:0];
              default: buffer        <= buffer;
            endcase
          end
          idx <= seq_last ? 2'd0 : idx + 2'd1;
        end
        default: idx <= 2'd0;
      endcase
    end
  end

  // Assemble the full load value on the last byte: earlier bytes from the
  // buffer, the current byte straight from memory in its little-endian lane.
  always_comb begin
    seq_word = {8'h0, buffer};
    case (idx)
      2'd1:    seq_word[15:8]  = dm_rd[7:0];
      2'd3:    seq_word[31:24] = dm_rd[7:0];
      default: seq_word        = {8'h0, buffer};
    endcase
  end

  // One extender serves both paths: live memory data for aligned loads and
  // the assembled word at the end of a split load.
  always_comb begin
    ext_size = size_n;
    ext_uns  = uns;
    ext_in   = dm_rd;
    if (state == LSU_SEQ) begin
      ext_size = size_q;
      ext_uns  = uns_q;
      ext_in   = seq_word;
    end
  end

  sm_lsu_ext u_ext (
    .size (ext_size),
    .uns  (ext_uns),
    .din  (ext_in),
    .dout (ext_out)
  );

  // Output logic: aligned requests complete in the cycle they appear, split
  // requests issue byte 0 from IDLE and the remaining bytes from SEQ, and
  // rejected requests complete at once without touching memory.
  always_comb begin
    rdata_c        = 32'h0;
    done_c         = 1'b0;
    stall_c        = 1'b0;
    misalign_err_c = 1'b0;
    dm_we_c        = 1'b0;
    dm_da          = size_n;
    dm_a           = addr;
    dm_wd          = wdata;
    case (state)
      LSU_IDLE: begin
        if (req) begin
          if (!misaligned) begin
            dm_we_c = we;
            done_c  = 1'b1;
            rdata_c = we ? 32'h0 : ext_out;
          end else if (MISALIGN_EN) begin
            dm_we_c = we;
            dm_da   = SIZE_BYTE;
            dm_wd   = {24'h0, wdata[7:0]};
            stall_c = 1'b1;
          end else begin
            misalign_err_c = 1'b1;
            done_c         = 1'b1;
          end
        end
      end
      LSU_SEQ: begin
        dm_we_c = we_q;
        dm_da   = SIZE_BYTE;
        dm_a    = addr_q + {30'h0, idx};
        dm_wd   = {24'h0, seq_wbyte};
        if (seq_last) begin
          done_c  = 1'b1;
          rdata_c = we_q ? 32'h0 : ext_out;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: begin
        dm_we_c = 1'b0;
      end
    endcase
  end

  // Handshake outputs and the memory write enable are held low throughout reset.
  assign rdata        = rst_n ? rdata_c : 32'h0;
  assign done         = rst_n & done_c;
  assign stall        = rst_n & stall_c;
  assign misalign_err = rst_n & misalign_err_c;
  assign dm_we        = rst_n & dm_we_c;

endmodule
